// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clips one rectangle command to the screen and emits its
// rows as frame-buffer write bursts of at most MAX_WRITE_BURST_LEN pixels.
// Optional feature macro: RECT_FILL_OUTLINE_EN (one-pixel outline mode).
// Without it, mode is ignored and every command is a solid fill.
//
// state | meaning
// IDLE  | waiting for start; command inputs latched on start
// SETUP | clip, reject empty/off-screen, load first segment
// REQ   | write_burst_req high, addr/len stable until data_req seen
// DATA  | pixels streaming, waiting for write_burst_data_finish
// NEXT  | pick next segment of the row, next row, or finish
// DONE  | one-cycle done pulse
module rect_fill_engine #(
    parameter int BURST_BITS          = 10,
    parameter int SCREEN_WIDTH        = 640,
    parameter int SCREEN_HEIGHT       = 480,
    parameter int MAX_WRITE_BURST_LEN = 128,
    parameter int BIT_SIZE            = 10,
    parameter int COLOR_BITS          = 16,
    parameter int BANK_BITS           = 2,
    parameter int ADDR_BITS           = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIT_SIZE-1:0]   x_pixel,
    input  logic [BIT_SIZE-1:0]   y_pixel,
    input  logic [BIT_SIZE-1:0]   width,
    input  logic [BIT_SIZE-1:0]   height,
    input  logic [COLOR_BITS-1:0] color,
    input  logic [BANK_BITS-1:0]  bank,
    input  logic                  mode,
    input  logic                  write_burst_data_req,
    input  logic                  write_burst_data_finish,
    output logic                  write_burst_req,
    output logic [BURST_BITS-1:0] write_burst_len,
    output logic [ADDR_BITS-1:0]  addr,
    output logic [COLOR_BITS-1:0] rgb,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = BIT_SIZE + 1;
    localparam int PW = ADDR_BITS - BANK_BITS;
    localparam int LW = (CW > BURST_BITS) ? CW : BURST_BITS;
    localparam logic [CW-1:0] SW_C  = CW'(SCREEN_WIDTH);
    localparam logic [CW-1:0] SH_C  = CW'(SCREEN_HEIGHT);
    localparam logic [LW-1:0] MAX_C = LW'(MAX_WRITE_BURST_LEN);
    localparam logic [PW-1:0] PITCH = PW'(SCREEN_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, REQ, DATA, NEXT, DONE} state_t;

    state_t state, state_nxt;

    logic [BIT_SIZE-1:0]   x_r, y_r, w_r, h_r;
    logic [COLOR_BITS-1:0] color_r;
    logic [BANK_BITS-1:0]  bank_r;
    logic                  is_outline;

    logic [CW-1:0] cur_x, cur_y;
    logic [PW-1:0] row_base;
    logic          phase;

    logic [CW-1:0] x_sum, y_sum, x_end, y_end, x_right, y_last;
    logic          empty, has_right, cur_full, cand_full, row_end;
    logic [CW-1:0] nx, cand_x, cand_y;
    logic [PW-1:0] cand_base;
    logic          cand_phase, cand_last;
    logic [LW-1:0] span, cand_len;

`ifdef RECT_FILL_OUTLINE_EN
    logic mode_r;

    // outline flag latched with the rest of the command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_r <= 1'b0;
        else if (state == IDLE && start)
            mode_r <= mode;
    end

    assign is_outline = mode_r;
`else
    wire unused_mode = mode;
    assign is_outline = 1'b0;
`endif

    // clipped extents (one extra bit so x+width never wraps)
    assign x_sum     = {1'b0, x_r} + {1'b0, w_r};
    assign y_sum     = {1'b0, y_r} + {1'b0, h_r};
    assign x_end     = (x_sum > SW_C) ? SW_C : x_sum;
    assign y_end     = (y_sum > SH_C) ? SH_C : y_sum;
    assign x_right   = x_sum - CW'(1);
    assign y_last    = y_sum - CW'(1);
    assign empty     = (w_r == '0) || (h_r == '0) ||
                       ({1'b0, x_r} >= SW_C) || ({1'b0, y_r} >= SH_C);
    assign has_right = (x_right < SW_C) && (x_right != {1'b0, x_r});
    assign cur_full  = !is_outline || (cur_y == {1'b0, y_r}) || (cur_y == y_last);

    // next segment: first one in SETUP, successor of the current one in NEXT
    always_comb begin
        cand_x     = {1'b0, x_r};
        cand_y     = {1'b0, y_r};
        cand_base  = PW'(y_r) * PITCH;
        cand_phase = 1'b0;
        cand_last  = empty;
        row_end    = 1'b1;
        nx         = cur_x + CW'(write_burst_len);
        if (state == NEXT) begin
            cand_y     = cur_y;
            cand_base  = row_base;
            cand_phase = phase;
            cand_last  = 1'b0;
            if (cur_full) begin
                if (nx < x_end) begin
                    cand_x  = nx;
                    row_end = 1'b0;
                end
            end else if (!phase && has_right) begin
                cand_x     = x_right;
                cand_phase = 1'b1;
                row_end    = 1'b0;
            end
            if (row_end) begin
                cand_x     = {1'b0, x_r};
                cand_y     = cur_y + CW'(1);
                cand_base  = row_base + PITCH;
                cand_phase = 1'b0;
                cand_last  = (cur_y + CW'(1)) >= y_end;
            end
        end
        cand_full = !is_outline || (cand_y == {1'b0, y_r}) || (cand_y == y_last);
        span      = LW'(x_end - cand_x);
        if (!cand_full)
            cand_len = LW'(1);
        else if (span > MAX_C)
            cand_len = MAX_C;
        else
            cand_len = span;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt       = state;
        write_burst_req = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = SETUP;
            end
            SETUP:   state_nxt = empty ? DONE : REQ;
            REQ: begin
                write_burst_req = 1'b1;
                if (write_burst_data_req)
                    state_nxt = DATA;
            end
            DATA: begin
                if (write_burst_data_finish)
                    state_nxt = NEXT;
            end
            NEXT:    state_nxt = cand_last ? DONE : REQ;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // command latch, segment walk and burst outputs (updated on entry to REQ)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r             <= '0;
            y_r             <= '0;
            w_r             <= '0;
            h_r             <= '0;
            color_r         <= '0;
            bank_r          <= '0;
            cur_x           <= '0;
            cur_y           <= '0;
            row_base        <= '0;
            phase           <= 1'b0;
            write_burst_len <= '0;
            addr            <= '0;
            rgb             <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                x_r     <= x_pixel;
                y_r     <= y_pixel;
                w_r     <= width;
                h_r     <= height;
                color_r <= color;
                bank_r  <= bank;
            end
        end else if ((state == SETUP || state == NEXT) && !cand_last) begin
            cur_x           <= cand_x;
            cur_y           <= cand_y;
            row_base        <= cand_base;
            phase           <= cand_phase;
            write_burst_len <= BURST_BITS'(cand_len);
            addr            <= {bank_r, cand_base + PW'(cand_x)};
            rgb             <= color_r;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed commands with hand-computed bursts queued in
// a scoreboard; a monitor pops one entry per new write_burst_req and a
// responder process plays the SDRAM controller side of the handshake.
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  x_pixel, y_pixel, width, height;
    logic [15:0] color;
    logic [1:0]  bank;
    logic        mode;
    logic        write_burst_data_req, write_burst_data_finish;
    logic        write_burst_req;
    logic [9:0]  write_burst_len;
    logic [23:0] addr;
    logic [15:0] rgb;
    logic        busy, done;

    typedef struct packed {
        logic [23:0] addr;
        logic [9:0]  len;
        logic [15:0] rgb;
    } burst_t;

    burst_t exp_q[$];
    int total = 0;
    int bad   = 0;

    rect_fill_engine dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .x_pixel                 (x_pixel),
        .y_pixel                 (y_pixel),
        .width                   (width),
        .height                  (height),
        .color                   (color),
        .bank                    (bank),
        .mode                    (mode),
        .write_burst_data_req    (write_burst_data_req),
        .write_burst_data_finish (write_burst_data_finish),
        .write_burst_req         (write_burst_req),
        .write_burst_len         (write_burst_len),
        .addr                    (addr),
        .rgb                     (rgb),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] b, input int off, input int len, input logic [15:0] c);
        burst_t e;
        e.addr = {b, 22'(off)};
        e.len  = 10'(len);
        e.rgb  = c;
        exp_q.push_back(e);
    endtask

    // start a command and check the two-cycle start latency
    task automatic issue(input string name, input int x, input int y, input int w, input int h,
                         input logic [15:0] c, input logic [1:0] b, input logic m, input bit is_empty);
        @(negedge clk);
        x_pixel = 10'(x);
        y_pixel = 10'(y);
        width   = 10'(w);
        height  = 10'(h);
        color   = c;
        bank    = b;
        mode    = m;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_rise"}, 64'(busy), 64'd1);
        @(negedge clk);
        if (is_empty) begin
            check({name, "_done_lat"}, 64'({done, write_burst_req}), 64'b10);
        end else begin
            check({name, "_req_lat"}, 64'(write_burst_req), 64'd1);
        end
    endtask

    // wait (bounded) for done, then confirm idle and all bursts consumed
    task automatic finish_cmd(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        @(negedge clk);
        check({name, "_busy_fall"}, 64'(busy), 64'd0);
        check({name, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor: one expected entry per new burst request
    initial begin
        logic   prev_req;
        burst_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (write_burst_req && !prev_req) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_burst actual addr=%0h len=%0d required none",
                                 addr, write_burst_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (addr !== e.addr || write_burst_len !== e.len || rgb !== e.rgb) begin
                            bad++;
                            $display("FAIL burst actual addr=%0h len=%0d rgb=%0h required addr=%0h len=%0d rgb=%0h",
                                     addr, write_burst_len, rgb, e.addr, e.len, e.rgb);
                        end
                    end
                end
                prev_req = write_burst_req;
            end
        end
    end

    // SDRAM controller model: take len pixels, then report burst finished
    initial begin
        int n;
        write_burst_data_req    = 1'b0;
        write_burst_data_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && write_burst_req) begin
                n = int'(write_burst_len);
                write_burst_data_req = 1'b1;
                @(negedge clk);
                if (rst_n)
                    check("req_drop", 64'(write_burst_req), 64'd0);
                for (int i = 1; i < n && rst_n; i++)
                    @(negedge clk);
                write_burst_data_req = 1'b0;
                if (rst_n) begin
                    write_burst_data_finish = 1'b1;
                    @(negedge clk);
                    write_burst_data_finish = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        x_pixel = '0;
        y_pixel = '0;
        width   = '0;
        height  = '0;
        color   = '0;
        bank    = '0;
        mode    = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({write_burst_req, write_burst_len, addr, rgb, busy, done}), 64'd0);
        rst_n = 1'b1;

        // basic solid fill, with a start pulse while busy that must be ignored
        push(2'd1, 1285, 10, 16'hA5A5);
        push(2'd1, 1925, 10, 16'hA5A5);
        push(2'd1, 2565, 10, 16'hA5A5);
        issue("basic", 5, 2, 10, 3, 16'hA5A5, 2'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        x_pixel = 10'd0;
        y_pixel = 10'd0;
        width   = 10'd5;
        height  = 10'd1;
        color   = 16'h1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_cmd("basic");
        repeat (4) @(negedge clk);
        check("ignored_start_idle", 64'(busy), 64'd0);

        // row split into max-length bursts plus remainder
        push(2'd0, 0, 128, 16'h00FF);
        push(2'd0, 128, 128, 16'h00FF);
        push(2'd0, 256, 44, 16'h00FF);
        issue("split", 0, 0, 300, 1, 16'h00FF, 2'd0, 1'b0, 1'b0);
        finish_cmd("split");

        // clipped at right and bottom edges
        push(2'd2, 306550, 10, 16'hBEEF);
        push(2'd2, 307190, 10, 16'hBEEF);
        issue("clip", 630, 478, 20, 5, 16'hBEEF, 2'd2, 1'b0, 1'b0);
        finish_cmd("clip");

        // outline 4x4
`ifdef RECT_FILL_OUTLINE_EN
        push(2'd0, 0, 4, 16'h7E7E);
        push(2'd0, 640, 1, 16'h7E7E);
        push(2'd0, 643, 1, 16'h7E7E);
        push(2'd0, 1280, 1, 16'h7E7E);
        push(2'd0, 1283, 1, 16'h7E7E);
        push(2'd0, 1920, 4, 16'h7E7E);
`else
        push(2'd0, 0, 4, 16'h7E7E);
        push(2'd0, 640, 4, 16'h7E7E);
        push(2'd0, 1280, 4, 16'h7E7E);
        push(2'd0, 1920, 4, 16'h7E7E);
`endif
        issue("outline", 0, 0, 4, 4, 16'h7E7E, 2'd0, 1'b1, 1'b0);
        finish_cmd("outline");

        // outline height 1: single row drawn once
        push(2'd3, 2, 3, 16'h0F0F);
        issue("outline_h1", 2, 0, 3, 1, 16'h0F0F, 2'd3, 1'b1, 1'b0);
        finish_cmd("outline_h1");

        // outline width 1: right column coincides with x, no second pixel
        push(2'd0, 650, 1, 16'h3333);
        push(2'd0, 1290, 1, 16'h3333);
        push(2'd0, 1930, 1, 16'h3333);
        issue("outline_w1", 10, 1, 1, 3, 16'h3333, 2'd0, 1'b1, 1'b0);
        finish_cmd("outline_w1");

        // empty and off-screen commands
        issue("empty_w0", 5, 5, 0, 4, 16'h1234, 2'd1, 1'b0, 1'b1);
        finish_cmd("empty_w0");
        issue("empty_h0", 5, 5, 4, 0, 16'h1234, 2'd1, 1'b0, 1'b1);
        finish_cmd("empty_h0");
        issue("offscreen_x", 700, 0, 10, 2, 16'h1234, 2'd1, 1'b0, 1'b1);
        finish_cmd("offscreen_x");
        issue("offscreen_y", 0, 480, 10, 2, 16'h1234, 2'd1, 1'b0, 1'b1);
        finish_cmd("offscreen_y");

        // reset in the middle of a burst, then a fresh command
        push(2'd0, 0, 10, 16'hCAFE);
        push(2'd0, 640, 10, 16'hCAFE);
        issue("pre_reset", 0, 0, 10, 2, 16'hCAFE, 2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_burst", 64'({write_burst_req, write_burst_len, addr, rgb, busy, done}), 64'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push(2'd3, 641, 2, 16'h5A5A);
        push(2'd3, 1281, 2, 16'h5A5A);
        issue("post_reset", 1, 1, 2, 2, 16'h5A5A, 2'd3, 1'b0, 1'b0);
        finish_cmd("post_reset");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
